// File: rtl/gol_step_ctrl_if.sv
// Button requests, engine grid feedback and sequencer outputs for the 8x8 Life engine.
// The master drives requests and the engine grid; the slave (sequencer) drives enables and status.
interface gol_step_ctrl_if #(
    parameter int GEN_W = 16
);
    logic             run_tgl;
    logic             step_req;
    logic             seed_req;
    logic [63:0]      seed_in;
    logic [63:0]      grid_in;
    logic             load_en;
    logic [63:0]      seed_out;
    logic             step_en;
    logic [GEN_W-1:0] gen_count;
    logic [2:0]       state;
    logic             stable;

    modport master (
        output run_tgl, step_req, seed_req, seed_in, grid_in,
        input  load_en, seed_out, step_en, gen_count, state, stable
    );

    modport slave (
        input  run_tgl, step_req, seed_req, seed_in, grid_in,
        output load_en, seed_out, step_en, gen_count, state, stable
    );
endinterface

// File: rtl/gol_step_ctrl.sv
// Life engine sequencer: load/step enables, RUN tick prescaler, generation count, auto-halt on stable grid.
// Enables are Moore outputs of the FSM; requests seen outside PAUSE/RUN/HALT are dropped, never queued.
module gol_step_ctrl #(
    parameter int          TICK_DIV = 12_500_000,
    parameter int          GEN_W    = 16,
    parameter logic [63:0] SEED_DEF = 64'h0412_6424_0034_3C28
) (
    input  logic           clk,
    input  logic           rst,
    gol_step_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_LOAD  = 3'd1,
        S_PAUSE = 3'd2,
        S_RUN   = 3'd3,
        S_STEP  = 3'd4,
        S_CHECK = 3'd5,
        S_HALT  = 3'd6
    } state_t;

    localparam int            PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t           state_q;
    state_t           state_d;
    logic [PW-1:0]    presc_q;
    logic [63:0]      seed_q;
    logic [63:0]      snap_q;
    logic [GEN_W-1:0] gen_q;
    logic             stable_q;
    logic             from_run_q;
    logic             load_en;
    logic             step_en;
    logic             presc_wrap;
    logic             grid_same;
    logic             grid_dead;
    logic             seed_take;

    assign presc_wrap = (presc_q == PRESC_LAST);
    assign grid_same  = (bus.grid_in == snap_q);
    assign grid_dead  = (bus.grid_in == '0);
    assign seed_take  = bus.seed_req &&
                        (state_q == S_PAUSE || state_q == S_RUN || state_q == S_HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  state_d = S_LOAD;
            S_LOAD:  state_d = S_PAUSE;
            S_PAUSE: begin
                if (bus.seed_req)      state_d = S_LOAD;
                else if (bus.step_req) state_d = S_STEP;
                else if (bus.run_tgl)  state_d = S_RUN;
            end
            // step_req has no meaning while free-running
            S_RUN: begin
                if (bus.seed_req)     state_d = S_LOAD;
                else if (bus.run_tgl) state_d = S_PAUSE;
                else if (presc_wrap)  state_d = S_STEP;
            end
            S_STEP:  state_d = S_CHECK;
            S_CHECK: begin
                if (grid_same || grid_dead) state_d = S_HALT;
                else if (from_run_q)        state_d = S_RUN;
                else                        state_d = S_PAUSE;
            end
            S_HALT: begin
                if (bus.seed_req)      state_d = S_LOAD;
                else if (bus.step_req) state_d = S_STEP;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        load_en = 1'b0;
        step_en = 1'b0;
        case (state_q)
            S_LOAD:  load_en = 1'b1;
            S_STEP:  step_en = 1'b1;
            default: ;
        endcase
    end

    // Prescaler only advances while RUN persists; any exit (pause, step, reseed) rearms it at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
        end else if (state_q == S_LOAD) begin
            presc_q <= '0;
        end else if (state_q == S_RUN) begin
            if (state_d != S_RUN) presc_q <= '0;
            else                  presc_q <= presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seed_q <= SEED_DEF;
        end else if (seed_take) begin
            seed_q <= bus.seed_in;
        end
    end

    // Origin of the step decides where CHECK returns to when the grid is still evolving.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            from_run_q <= 1'b0;
        end else if (state_d == S_STEP && state_q != S_STEP) begin
            from_run_q <= (state_q == S_RUN);
        end
    end

    // grid_in during STEP is still the pre-step generation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_q <= '0;
        end else if (state_q == S_STEP) begin
            snap_q <= bus.grid_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gen_q <= '0;
        end else if (state_q == S_LOAD) begin
            gen_q <= '0;
        end else if (state_q == S_STEP && gen_q != '1) begin
            gen_q <= gen_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_q <= 1'b0;
        end else if (state_q == S_LOAD) begin
            stable_q <= 1'b0;
        end else if (state_q == S_CHECK) begin
            stable_q <= grid_same;
        end
    end

    assign bus.load_en   = load_en;
    assign bus.step_en   = step_en;
    assign bus.seed_out  = seed_q;
    assign bus.gen_count = gen_q;
    assign bus.state     = state_q;
    assign bus.stable    = stable_q;

endmodule

// File: tb/tb_gol_step_ctrl.sv
// Bench for gol_step_ctrl: bench-side Life engine plus a generation/timing reference model.
module tb_gol_step_ctrl;

    localparam int          TD       = 4;
    localparam logic [63:0] SEED_DEF = 64'h0412_6424_0034_3C28;
    localparam logic [63:0] BLINK    = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLOCK    = 64'h0000_0000_0C0C_0000;
    localparam logic [63:0] GLIDER   = 64'h0000_0000_0007_0402;
    localparam logic [2:0]  ST_INIT  = 3'd0;
    localparam logic [2:0]  ST_LOAD  = 3'd1;
    localparam logic [2:0]  ST_PAUSE = 3'd2;
    localparam logic [2:0]  ST_RUN   = 3'd3;
    localparam logic [2:0]  ST_HALT  = 3'd6;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gol_step_ctrl_if #(.GEN_W(16)) b ();
    gol_step_ctrl_if #(.GEN_W(2))  b2 ();

    gol_step_ctrl #(.TICK_DIV(TD), .GEN_W(16), .SEED_DEF(SEED_DEF)) dut (
        .clk(clk), .rst(rst), .bus(b)
    );
    gol_step_ctrl #(.TICK_DIV(TD), .GEN_W(2), .SEED_DEF(SEED_DEF)) dut2 (
        .clk(clk), .rst(rst2), .bus(b2)
    );

    // Life rule on an 8x8 grid with dead cells beyond the border; bit index = row*8 + col.
    function automatic logic [63:0] life(input logic [63:0] g);
        logic [63:0] n;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 &&
                            c + dc >= 0 && c + dc < 8)
                            cnt += int'(g[(r + dr) * 8 + c + dc]);
                n[r * 8 + c] = (cnt == 3) || (g[r * 8 + c] && cnt == 2);
            end
        end
        return n;
    endfunction

    logic [63:0] eng  = '0;
    logic [63:0] eng2 = '0;
    always @(posedge clk) begin
        if (b.load_en)      eng <= b.seed_out;
        else if (b.step_en) eng <= life(eng);
        if (b2.load_en)      eng2 <= b2.seed_out;
        else if (b2.step_en) eng2 <= life(eng2);
    end
    assign b.grid_in  = eng;
    assign b2.grid_in = eng2;

    logic prev_load = 1'b0;
    logic prev_step = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            vectors++;
            if ((b.load_en && b.step_en) || (b.load_en && prev_step) || (b.step_en && prev_load)) begin
                miscompares++;
                $display("FAIL en_exclusive at cycle %0d: load_en=%b step_en=%b prev_load=%b prev_step=%b required no overlap",
                         cyc, b.load_en, b.step_en, prev_load, prev_step);
            end
        end
        prev_load <= rst & b.load_en;
        prev_step <= rst & b.step_en;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_seed(input logic [63:0] s);
        b.seed_in = s; b.seed_req = 1'b1; tick();
        b.seed_req = 1'b0; b.seed_in = ~s; tick();
    endtask

    task automatic wait_step(input bit sel, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = sel ? b2.step_en : b.step_en;
        end
    endtask

    function automatic logic [63:0] rand_grid();
        return {$urandom, $urandom} & {$urandom, $urandom};
    endfunction

    task automatic test_reset();
        int first = 0;
        int loads = 0;
        tick(); tick();
        vectors++;
        if (b.state !== ST_INIT || b.load_en !== 1'b0 || b.step_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got state=%0d load=%b step=%b want 0/0/0", b.state, b.load_en, b.step_en);
        end
        vectors++;
        if (b.seed_out !== SEED_DEF || b.gen_count !== 16'd0 || b.stable !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_data got seed=%h gen=%0d stable=%b want %h/0/0", b.seed_out, b.gen_count, b.stable, SEED_DEF);
        end
        rst = 1'b1;
        // cycle 1 is the clock period in which reset is released (INIT)
        for (int i = 2; i < 10; i++) begin
            tick();
            if (b.load_en) begin
                loads++;
                if (first == 0) first = i;
                vectors++;
                if (b.seed_out !== SEED_DEF) begin
                    miscompares++;
                    $display("FAIL reset_load_seed got %h want %h", b.seed_out, SEED_DEF);
                end
            end
        end
        vectors++;
        if (first != 2 || loads != 1) begin
            miscompares++;
            $display("FAIL reset_load_pulse got cycle=%0d count=%0d want cycle=2 count=1", first, loads);
        end
        vectors++;
        if (b.state !== ST_PAUSE || b.gen_count !== 16'd0 || eng !== SEED_DEF) begin
            miscompares++;
            $display("FAIL reset_after got state=%0d gen=%0d grid=%h want 2/0/%h", b.state, b.gen_count, eng, SEED_DEF);
        end
    endtask

    task automatic test_run_blinker();
        int  c0;
        bit  ok;
        logic [63:0] g = BLINK;
        do_seed(BLINK);
        vectors++;
        if (b.seed_out !== BLINK || b.state !== ST_PAUSE || b.gen_count !== 16'd0) begin
            miscompares++;
            $display("FAIL blink_seed got seed=%h state=%0d gen=%0d want %h/2/0", b.seed_out, b.state, b.gen_count, BLINK);
        end
        b.run_tgl = 1'b1; c0 = cyc; tick(); b.run_tgl = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            wait_step(1'b0, 20, ok);
            vectors++;
            if (!ok || cyc - c0 != ((k == 1) ? TD + 1 : TD + 2)) begin
                miscompares++;
                $display("FAIL blink_period%0d got ok=%b dist=%0d want %0d", k, ok, cyc - c0, (k == 1) ? TD + 1 : TD + 2);
            end
            c0 = cyc;
            g = life(g);
            tick();
            vectors++;
            if (b.gen_count !== 16'(k)) begin
                miscompares++;
                $display("FAIL blink_gen got %0d want %0d", b.gen_count, k);
            end
            tick();
            vectors++;
            if (b.stable !== 1'b0 || b.state !== ST_RUN || eng !== g) begin
                miscompares++;
                $display("FAIL blink_post got stable=%b state=%0d grid=%h want 0/3/%h", b.stable, b.state, eng, g);
            end
        end
        b.run_tgl = 1'b1; tick(); b.run_tgl = 1'b0;
        vectors++;
        if (b.state !== ST_PAUSE) begin
            miscompares++;
            $display("FAIL blink_pause got state=%0d want 2", b.state);
        end
    endtask

    task automatic test_still_life();
        bit ok;
        int extra = 0;
        do_seed(BLOCK);
        b.run_tgl = 1'b1; tick(); b.run_tgl = 1'b0;
        wait_step(1'b0, 20, ok);
        tick(); tick();
        vectors++;
        if (!ok || b.stable !== 1'b1 || b.state !== ST_HALT || b.gen_count !== 16'd1) begin
            miscompares++;
            $display("FAIL still_halt got ok=%b stable=%b state=%0d gen=%0d want 1/1/6/1", ok, b.stable, b.state, b.gen_count);
        end
        b.run_tgl = 1'b1; tick(); b.run_tgl = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (b.step_en) extra++;
            tick();
        end
        vectors++;
        if (extra != 0 || b.state !== ST_HALT) begin
            miscompares++;
            $display("FAIL still_quiet got steps=%0d state=%0d want 0/6", extra, b.state);
        end
    endtask

    task automatic test_single_step();
        for (int t = 0; t < 4; t++) begin
            logic [63:0] g  = (t == 0) ? BLINK : rand_grid();
            logic [63:0] ng;
            bit          halt;
            do_seed(g);
            for (int k = 1; k <= 3; k++) begin
                b.step_req = 1'b1; tick(); b.step_req = 1'b0;
                vectors++;
                if (b.step_en !== 1'b1) begin
                    miscompares++;
                    $display("FAIL sstep_en t%0d k%0d got %b want 1", t, k, b.step_en);
                end
                ng = life(g);
                halt = (ng == g) || (ng == '0);
                // a run toggle landing while STEP is active must be dropped
                if (k == 2) b.run_tgl = 1'b1;
                tick(); b.run_tgl = 1'b0;
                vectors++;
                if (b.gen_count !== 16'(k)) begin
                    miscompares++;
                    $display("FAIL sstep_gen t%0d got %0d want %0d", t, b.gen_count, k);
                end
                tick();
                vectors++;
                if (b.stable !== (ng == g) || b.state !== (halt ? ST_HALT : ST_PAUSE)) begin
                    miscompares++;
                    $display("FAIL sstep_post t%0d k%0d got stable=%b state=%0d want %b/%0d",
                             t, k, b.stable, b.state, ng == g, halt ? ST_HALT : ST_PAUSE);
                end
                g = ng;
                tick(); tick();
            end
        end
    endtask

    task automatic test_random_run();
        for (int t = 0; t < 4; t++) begin
            logic [63:0] g = rand_grid();
            logic [63:0] ng;
            bit          halt = 1'b0;
            bit          ok;
            int          c0;
            int          extra = 0;
            do_seed(g);
            b.run_tgl = 1'b1; c0 = cyc; tick(); b.run_tgl = 1'b0;
            for (int k = 1; k <= 6 && !halt; k++) begin
                wait_step(1'b0, 20, ok);
                vectors++;
                if (!ok || cyc - c0 != ((k == 1) ? TD + 1 : TD + 2)) begin
                    miscompares++;
                    $display("FAIL rrun_period t%0d k%0d got ok=%b dist=%0d", t, k, ok, cyc - c0);
                end
                c0 = cyc;
                ng = life(g);
                halt = (ng == g) || (ng == '0);
                tick();
                vectors++;
                if (b.gen_count !== 16'(k)) begin
                    miscompares++;
                    $display("FAIL rrun_gen t%0d got %0d want %0d", t, b.gen_count, k);
                end
                tick();
                vectors++;
                if (b.stable !== (ng == g) || b.state !== (halt ? ST_HALT : ST_RUN)) begin
                    miscompares++;
                    $display("FAIL rrun_post t%0d k%0d got stable=%b state=%0d want %b/%0d",
                             t, k, b.stable, b.state, ng == g, halt ? ST_HALT : ST_RUN);
                end
                g = ng;
            end
            if (halt) begin
                for (int i = 0; i < 10; i++) begin
                    tick();
                    if (b.step_en) extra++;
                end
                vectors++;
                if (extra != 0) begin
                    miscompares++;
                    $display("FAIL rrun_halted t%0d got %0d steps want 0", t, extra);
                end
            end else begin
                b.run_tgl = 1'b1; tick(); b.run_tgl = 1'b0;
                vectors++;
                if (b.state !== ST_PAUSE) begin
                    miscompares++;
                    $display("FAIL rrun_pause t%0d got state=%0d want 2", t, b.state);
                end
            end
        end
    endtask

    task automatic test_seed_priority();
        logic [63:0] s = rand_grid() | 64'h1;
        bit ok;
        do_seed(BLINK);
        b.run_tgl = 1'b1; tick(); b.run_tgl = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wait_step(1'b0, 20, ok);
            tick(); tick();
        end
        b.seed_in = s; b.seed_req = 1'b1; b.run_tgl = 1'b1; tick();
        b.seed_req = 1'b0; b.run_tgl = 1'b0; b.seed_in = ~s;
        vectors++;
        if (b.state !== ST_LOAD || b.load_en !== 1'b1) begin
            miscompares++;
            $display("FAIL prio_load got state=%0d load=%b want 1/1", b.state, b.load_en);
        end
        tick();
        vectors++;
        if (b.state !== ST_PAUSE || b.seed_out !== s || b.gen_count !== 16'd0 || b.stable !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_after got state=%0d seed=%h gen=%0d stable=%b want 2/%h/0/0",
                     b.state, b.seed_out, b.gen_count, b.stable, s);
        end
    endtask

    task automatic test_saturate();
        bit ok;
        tick(); rst2 = 1'b1; tick(); tick();
        b2.seed_in = GLIDER; b2.seed_req = 1'b1; tick();
        b2.seed_req = 1'b0; b2.seed_in = '0; tick();
        vectors++;
        if (b2.seed_out !== GLIDER || b2.state !== ST_PAUSE) begin
            miscompares++;
            $display("FAIL sat_seed got seed=%h state=%0d want %h/2", b2.seed_out, b2.state, GLIDER);
        end
        b2.run_tgl = 1'b1; tick(); b2.run_tgl = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            wait_step(1'b1, 20, ok);
            tick();
            vectors++;
            if (!ok || b2.gen_count !== 2'((k > 3) ? 3 : k)) begin
                miscompares++;
                $display("FAIL sat_gen k%0d got ok=%b gen=%0d want %0d", k, ok, b2.gen_count, (k > 3) ? 3 : k);
            end
            tick();
        end
        wait_step(1'b1, 20, ok);
        rst2 = 1'b0;
        #1;
        vectors++;
        if (!ok || b2.step_en !== 1'b0 || b2.state !== ST_INIT || b2.gen_count !== 2'd0 ||
            b2.seed_out !== SEED_DEF || b2.stable !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_async_rst got ok=%b step=%b state=%0d gen=%0d seed=%h stable=%b",
                     ok, b2.step_en, b2.state, b2.gen_count, b2.seed_out, b2.stable);
        end
        tick(); rst2 = 1'b1; tick();
        vectors++;
        if (b2.load_en !== 1'b1 || b2.seed_out !== SEED_DEF) begin
            miscompares++;
            $display("FAIL sat_reload got load=%b seed=%h want 1/%h", b2.load_en, b2.seed_out, SEED_DEF);
        end
        tick();
        vectors++;
        if (b2.state !== ST_PAUSE || eng2 !== SEED_DEF) begin
            miscompares++;
            $display("FAIL sat_reload_pause got state=%0d grid=%h want 2/%h", b2.state, eng2, SEED_DEF);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; rst2 = 1'b1;
        b.run_tgl = 1'b0; b.step_req = 1'b0; b.seed_req = 1'b0; b.seed_in = '0;
        b2.run_tgl = 1'b0; b2.step_req = 1'b0; b2.seed_req = 1'b0; b2.seed_in = '0;
        #1;
        rst = 1'b0; rst2 = 1'b0;
        test_reset();
        test_run_blinker();
        test_still_life();
        test_single_step();
        test_random_run();
        test_seed_priority();
        test_saturate();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
